// File: rtl/axis_out_shift_db.sv
// AXI-stream column serializer: buffers whole [COLS][ROWS] transactions and
// emits the kw-selected columns, highest first, one beat per cycle.
`timescale 1ns/1ps

`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 8
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 32
`endif
`ifndef BITS_KW2
`define BITS_KW2 3
`endif

package axis_out_shift_db_pkg;
  typedef struct packed {
    logic [`BITS_KW2-1:0] kw2;
  } tuser_st;
endpackage

module axis_out_shift_db
  import axis_out_shift_db_pkg::*;
#(
  parameter int ROWS       = `ROWS,
  parameter int COLS       = `COLS,
  parameter int WORD_WIDTH = `WORD_WIDTH_ACC,
  parameter int BITS_KW2   = `BITS_KW2,
  parameter int DEPTH      = 2
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_last,
  input  tuser_st                         s_user,
  input  logic [COLS*ROWS*WORD_WIDTH-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [ROWS*WORD_WIDTH-1:0]      m_data,
  output tuser_st                         m_user,
  output logic                            m_last
);

  localparam int BW = ROWS * WORD_WIDTH;
  localparam int DW = COLS * BW;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int KW = BITS_KW2 + 2;

  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_last [DEPTH];
  tuser_st       mem_user [DEPTH];
  logic [KW-1:0] mem_kw   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] col;

  logic [DW-1:0]   h_data;
  logic            h_last;
  logic [KW-1:0]   h_kw;
  logic [COLS-1:0] emit_mask;
  logic [COLS-1:0] last_mask;
  logic [CW-1:0]   cur_col;
  logic            found;
  logic            lower;
  logic            busy;
  logic            fire;
  logic            retire;
  logic            accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign h_data = mem_data[rd_ptr];
  assign h_last = mem_last[rd_ptr];
  assign h_kw   = mem_kw[rd_ptr];

  // Column c+1 is a window end, or a partial trailing window past its centre
  always_comb begin
    int kwi;
    int pos;
    int rem;
    emit_mask = '0;
    last_mask = '0;
    kwi = int'(h_kw);
    for (int c = 0; c < COLS; c++) begin
      pos = c + 1;
      rem = pos % kwi;
      emit_mask[c] = (rem == 0) || (h_last && (rem > kwi / 2));
      last_mask[c] = h_last && (pos == kwi / 2 + 1);
    end
  end

  // Highest emitted column at or below col; skipped columns cost no cycle
  always_comb begin
    found   = 1'b0;
    cur_col = '0;
    lower   = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (emit_mask[c] && (CW'(c) <= col)) begin
        found   = 1'b1;
        cur_col = CW'(c);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (emit_mask[c] && (CW'(c) < cur_col)) begin
        lower = 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (count != '0);
    m_valid = busy && found;
    fire    = m_valid && m_ready;
    retire  = busy && (!found || (fire && !lower));
    s_ready = !areset && ((count < NW'(DEPTH)) || retire);
    accept  = s_valid && s_ready;
    m_data  = m_valid ? h_data[int'(cur_col)*BW +: BW] : '0;
    m_user  = m_valid ? mem_user[rd_ptr] : '0;
    m_last  = m_valid && last_mask[cur_col];
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_data[wr_ptr] <= s_data;
      mem_last[wr_ptr] <= s_last;
      mem_user[wr_ptr] <= s_user;
      mem_kw[wr_ptr]   <= KW'({1'b0, s_user.kw2, 1'b1});
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      col    <= CW'(COLS - 1);
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (retire) begin
        rd_ptr <= ptr_inc(rd_ptr);
        col    <= CW'(COLS - 1);
      end else if (fire) begin
        col <= cur_col - 1'b1;
      end
      unique case (1'b1)
        accept && !retire: count <= count + 1'b1;
        retire && !accept: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_out_shift_db.sv
// Bench for axis_out_shift_db: table of kw/last patterns, directed
// latency/backpressure/reset sequences and a randomized scoreboard run.
`timescale 1ns/1ps

module tb_axis_out_shift_db;
  import axis_out_shift_db_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int WW    = 32;
  localparam int BK    = 3;
  localparam int DEPTH = 2;
  localparam int BW    = ROWS * WW;
  localparam int DW    = COLS * BW;

  logic          aclk    = 1'b0;
  logic          areset  = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic          m_ready = 1'b0;
  tuser_st       s_user  = '0;
  logic [DW-1:0] s_data  = '0;
  logic          s_ready;
  logic          m_valid;
  logic          m_last;
  logic [BW-1:0] m_data;
  tuser_st       m_user;

  axis_out_shift_db #(
    .ROWS(ROWS), .COLS(COLS), .WORD_WIDTH(WW),
    .BITS_KW2(BK), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_user(s_user), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_user(m_user), .m_last(m_last)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  logic ready_rand = 1'b0;
  logic ready_fix  = 1'b1;
  always @(posedge aclk) begin
    #1;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  typedef struct {
    logic [BW-1:0] data;
    tuser_st       user;
    logic          last;
    int            col;
  } beat_t;

  typedef struct {
    int            kw2;
    logic          last;
    logic [COLS-1:0] mask;
    int            lastcol;
  } vec_t;

  beat_t q[$];
  int vectors = 0;
  int errors  = 0;
  logic [COLS-1:0] obs_mask;
  int obs_lastcol;
  int obs_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every column whose 1-based position closes a kw window,
  // or (last only) lands past the middle of a trailing partial window
  function automatic void model_push(input logic [DW-1:0] d,
                                     input tuser_st u, input logic l);
    int kw;
    int rem;
    beat_t b;
    kw = 2 * int'(u.kw2) + 1;
    for (int c = COLS - 1; c >= 0; c--) begin
      rem = (c + 1) % kw;
      if (rem == 0 || (l && rem > kw / 2)) begin
        b.data = d[c*BW +: BW];
        b.user = u;
        b.last = l && ((c + 1) == kw / 2 + 1);
        b.col  = c;
        q.push_back(b);
      end
    end
  endfunction

  logic          stall_pend = 1'b0;
  logic [BW-1:0] st_data;
  tuser_st       st_user;
  logic          st_last;

  always @(negedge aclk) begin
    beat_t e;
    if (areset) begin
      q.delete();
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        vectors++;
        if (!m_valid || m_data !== st_data || m_user !== st_user ||
            m_last !== st_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h l=%0b expected d=%h l=%0b",
                   m_valid, m_data, m_last, st_data, st_last);
        end
      end
      if (m_valid && m_ready) begin
        vectors++;
        obs_cyc.push_back(cyc);
        if (int'(m_data[7:0]) < COLS) obs_mask[m_data[7:0]] = 1'b1;
        if (m_last) obs_lastcol = int'(m_data[7:0]);
        if (q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got d=%h expected no beat", m_data);
        end else begin
          e = q.pop_front();
          if (m_data !== e.data || m_user !== e.user || m_last !== e.last) begin
            errors++;
            $display("FAIL beat_col%0d: got d=%h u=%0d l=%0b expected d=%h u=%0d l=%0b",
                     e.col, m_data, m_user.kw2, m_last, e.data, e.user.kw2, e.last);
          end
        end
      end
      stall_pend = m_valid && !m_ready;
      st_data = m_data;
      st_user = m_user;
      st_last = m_last;
      if (s_valid && s_ready) model_push(s_data, s_user, s_last);
    end
  end

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  task automatic make_data();
    logic [WW-1:0] w;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        w = $urandom;
        w[7:0]  = 8'(c);
        w[15:8] = 8'(r);
        s_data[(c*ROWS+r)*WW +: WW] = w;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input int kw2, input logic last, output int waited);
    logic ok;
    make_data();
    s_user.kw2 = BK'(kw2);
    s_last  = last;
    s_valid = 1'b1;
    waited  = 0;
    ok      = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (s_ready) ok = 1'b1;
      else waited++;
      @(posedge aclk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge aclk);
      if (q.size() == 0 && !m_valid) idle = 1'b1;
    end
    sync();
    sync();
    chk("drain_q", q.size(), 0);
  endtask

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w1;
    int w2;
    int wsum;
    tbl[0]  = '{0, 1'b0, 8'hFF, -1};
    tbl[1]  = '{0, 1'b1, 8'hFF, 0};
    tbl[2]  = '{1, 1'b0, 8'h24, -1};
    tbl[3]  = '{1, 1'b1, 8'hB6, 1};
    tbl[4]  = '{2, 1'b0, 8'h10, -1};
    tbl[5]  = '{2, 1'b1, 8'h9C, 2};
    tbl[6]  = '{3, 1'b0, 8'h40, -1};
    tbl[7]  = '{3, 1'b1, 8'h78, 3};
    tbl[8]  = '{4, 1'b0, 8'h00, -1};
    tbl[9]  = '{4, 1'b1, 8'hF0, 4};
    tbl[10] = '{7, 1'b0, 8'h00, -1};
    tbl[11] = '{7, 1'b1, 8'h80, 7};

    areset = 1'b1;
    sync();
    sync();
    @(negedge aclk);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(|m_data), 0);
    sync();
    areset = 1'b0;
    @(negedge aclk);
    chk("rel_s_ready", int'(s_ready), 1);
    sync();

    send(0, 1'b0, w1);
    @(negedge aclk);
    chk("lat_valid", int'(m_valid), 1);
    chk("lat_col", int'(m_data[7:0]), 7);
    sync();
    wait_idle();

    foreach (tbl[i]) begin
      obs_mask = '0;
      obs_lastcol = -1;
      send(tbl[i].kw2, tbl[i].last, w1);
      wait_idle();
      chk($sformatf("tbl%0d_cols", i), int'(obs_mask), int'(tbl[i].mask));
      chk($sformatf("tbl%0d_lastcol", i), obs_lastcol, tbl[i].lastcol);
    end

    obs_cyc.delete();
    send(0, 1'b0, w1);
    send(0, 1'b0, w2);
    chk("b2b_wait1", w1, 0);
    chk("b2b_wait2", w2, 0);
    wait_idle();
    chk("b2b_beats", obs_cyc.size(), 16);
    if (obs_cyc.size() == 16) chk("b2b_span", obs_cyc[15] - obs_cyc[0], 15);

    ready_fix = 1'b0;
    sync();
    send(0, 1'b0, w1);
    send(0, 1'b0, w2);
    @(negedge aclk);
    chk("full_s_ready", int'(s_ready), 0);
    chk("full_head_col", int'(m_data[7:0]), 7);
    sync();
    ready_fix = 1'b1;
    wait_idle();

    ready_rand = 1'b1;
    obs_mask = '0;
    send(0, 1'b0, w1);
    wait_idle();
    chk("stall_cols", int'(obs_mask), 8'hFF);
    ready_rand = 1'b0;
    sync();

    obs_cyc.delete();
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send(4, 1'b0, w1);
      wsum += w1;
    end
    wait_idle();
    chk("zero_beat_wait", wsum, 0);
    chk("zero_beat_cnt", obs_cyc.size(), 0);

    send(0, 1'b1, w1);
    sync();
    areset = 1'b1;
    sync();
    @(negedge aclk);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    sync();
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_rel_ready", int'(s_ready), 1);
    chk("midrst_rel_valid", int'(m_valid), 0);
    sync();

    ready_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send($urandom_range(0, 7), 1'($urandom_range(0, 1)), w1);
      repeat ($urandom_range(0, 2)) sync();
    end
    wait_idle();
    ready_rand = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
